// File: rtl/gl_cmd_writer.sv
// gl_cmd_writer
// Writes a host command stream into an instruction BRAM as a command list.
// Each packet starts with a header whose low byte selects the packet length.
// Packets that would not leave room for a closing JMP are dropped and
// flagged. A JMP closes the list and rewinds the write pointer.
//
// Ports
//   clk        single clock, all outputs registered on its rising edge
//   reset      asynchronous active-high reset
//   cmd_in     command word (header or payload)
//   cmd_valid  cmd_in holds a valid word
//   hold       BRAM port unavailable, nothing accepted while high
//   cmd_ready  word accepted when cmd_valid && cmd_ready
//   bram_we    one-cycle write strobe
//   bram_addr  write address (holds last value)
//   bram_data  write data (holds last value)
//   list_done  one-cycle pulse alongside the JMP write
//   overflow   sticky: a packet was dropped for lack of space
//   busy       a packet is partially received
//
// state   | meaning
// IDLE    | waiting for a header
// PAYLOAD | writing the remaining words of an accepted packet
// DROP    | discarding the remaining words of a packet that did not fit
module gl_cmd_writer #(
  parameter int width      = 32,
  parameter int depth      = 1024,
  parameter int text_start = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] cmd_in,
  input  logic             cmd_valid,
  input  logic             hold,
  output logic             cmd_ready,
  output logic             bram_we,
  output logic [width-1:0] bram_addr,
  output logic [width-1:0] bram_data,
  output logic             list_done,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, PAYLOAD, DROP} state_t;

  state_t           state;
  logic [width-1:0] wr_ptr;
  logic [width-1:0] remaining;
  logic [width-1:0] hdr_len;
  logic [width:0]   end_sum;
  logic             accept;
  logic             is_jmp;
  logic             fits;

  assign cmd_ready = ~hold & ~reset;
  assign accept    = cmd_valid & cmd_ready;
  assign is_jmp    = (cmd_in[7:0] == 8'h06);

  always_comb begin
    hdr_len = width'(1);
    case (cmd_in[7:0])
      8'h03, 8'h04:                                    hdr_len = width'(4);
      8'h11, 8'h13, 8'h16, 8'h17, 8'h18, 8'h1A, 8'h1B: hdr_len = width'(17);
      8'h19:                                           hdr_len = width'(5);
      default:                                         hdr_len = width'(1);
    endcase
  end

  // Extra bit keeps the sum from wrapping near the top of the pointer range.
  // The bound is depth-1 so one slot always remains for a closing JMP.
  assign end_sum = {1'b0, wr_ptr} + {1'b0, hdr_len};
  assign fits    = (end_sum <= (width+1)'(depth - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wr_ptr    <= width'(text_start);
      remaining <= '0;
      bram_we   <= 1'b0;
      bram_addr <= '0;
      bram_data <= '0;
      list_done <= 1'b0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      bram_we   <= 1'b0;
      list_done <= 1'b0;
      if (accept) begin
        case (state)
          IDLE: begin
            if (is_jmp) begin
              bram_we   <= 1'b1;
              bram_addr <= wr_ptr;
              bram_data <= cmd_in;
              list_done <= 1'b1;
              wr_ptr    <= width'(text_start);
            end else if (fits) begin
              bram_we   <= 1'b1;
              bram_addr <= wr_ptr;
              bram_data <= cmd_in;
              wr_ptr    <= wr_ptr + width'(1);
              if (hdr_len > width'(1)) begin
                remaining <= hdr_len - width'(1);
                state     <= PAYLOAD;
                busy      <= 1'b1;
              end
            end else begin
              overflow <= 1'b1;
              if (hdr_len > width'(1)) begin
                remaining <= hdr_len - width'(1);
                state     <= DROP;
                busy      <= 1'b1;
              end
            end
          end
          PAYLOAD: begin
            bram_we   <= 1'b1;
            bram_addr <= wr_ptr;
            bram_data <= cmd_in;
            wr_ptr    <= wr_ptr + width'(1);
            remaining <= remaining - width'(1);
            if (remaining == width'(1)) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          DROP: begin
            remaining <= remaining - width'(1);
            if (remaining == width'(1)) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gl_cmd_writer.sv
module tb_gl_cmd_writer;

  localparam int W     = 32;
  localparam int DEPTH = 32;
  localparam int TS    = 0;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  cmd_in;
  logic          cmd_valid;
  logic          hold;
  logic          cmd_ready;
  logic          bram_we;
  logic [W-1:0]  bram_addr;
  logic [W-1:0]  bram_data;
  logic          list_done;
  logic          overflow;
  logic          busy;

  int vectors     = 0;
  int miscompares = 0;

  gl_cmd_writer #(.width(W), .depth(DEPTH), .text_start(TS)) dut (
    .clk(clk), .reset(reset), .cmd_in(cmd_in), .cmd_valid(cmd_valid),
    .hold(hold), .cmd_ready(cmd_ready), .bram_we(bram_we),
    .bram_addr(bram_addr), .bram_data(bram_data), .list_done(list_done),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  // Scoreboard of expected BRAM writes.
  logic [W-1:0] q_addr[$];
  logic [W-1:0] q_data[$];
  bit           q_jmp[$];

  // Reference model: list position, words left in current packet, drop mode.
  int m_ptr;
  int m_rem;
  bit m_drop;
  bit m_ovf;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pkt_len(input logic [7:0] op);
    case (op)
      8'h03, 8'h04: return 4;
      8'h11, 8'h13, 8'h16, 8'h17, 8'h18, 8'h1A, 8'h1B: return 17;
      8'h19: return 5;
      default: return 1;
    endcase
  endfunction

  task automatic model_reset();
    m_ptr = TS; m_rem = 0; m_drop = 0; m_ovf = 0;
  endtask

  task automatic expect_write(input int a, input logic [W-1:0] d, input bit j);
    q_addr.push_back(W'(a));
    q_data.push_back(d);
    q_jmp.push_back(j);
  endtask

  task automatic model_accept(input logic [W-1:0] w);
    int len;
    if (m_rem == 0) begin
      len = pkt_len(w[7:0]);
      if (w[7:0] == 8'h06) begin
        expect_write(m_ptr, w, 1'b1);
        m_ptr = TS;
      end else if (m_ptr + len <= DEPTH - 1) begin
        expect_write(m_ptr, w, 1'b0);
        m_ptr++;
        m_rem = len - 1;
        m_drop = 0;
      end else begin
        m_ovf = 1;
        m_rem = len - 1;
        m_drop = 1;
      end
    end else begin
      if (!m_drop) begin
        expect_write(m_ptr, w, 1'b0);
        m_ptr++;
      end
      m_rem--;
    end
  endtask

  // Monitor: every write strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bram_we === 1'b1) begin
      if (q_addr.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: addr %h data %h, none expected", bram_addr, bram_data);
      end else begin
        chk("write_addr", bram_addr, q_addr.pop_front());
        chk("write_data", bram_data, q_data.pop_front());
        chk("list_done", {31'b0, list_done}, {31'b0, q_jmp.pop_front()});
      end
    end else if (list_done !== 1'b0) begin
      vectors++;
      miscompares++;
      $display("FAIL list_done_alone: got %b expected 0", list_done);
    end
  end

  task automatic send_word(input logic [W-1:0] w, input bit rand_hold);
    bit done = 0;
    int guard = 0;
    while (!done) begin
      cmd_in    = w;
      cmd_valid = 1'b1;
      hold      = (rand_hold && guard < 40) ? ($urandom_range(0, 2) == 0) : 1'b0;
      guard++;
      @(negedge clk);
      chk("cmd_ready", {31'b0, cmd_ready}, {31'b0, ~hold});
      @(posedge clk);
      if (!hold) begin
        model_accept(w);
        done = 1;
      end
      #1;
    end
    cmd_valid = 1'b0;
    hold      = 1'b0;
    chk("busy", {31'b0, busy}, {31'b0, m_rem != 0});
    chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
  endtask

  task automatic send_packet(input logic [W-1:0] hdr, input bit rand_hold, input bit rand_gap);
    int n;
    n = pkt_len(hdr[7:0]);
    send_word(hdr, rand_hold);
    for (int i = 1; i < n; i++) begin
      if (rand_gap && $urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      send_word(($urandom_range(0, 4) == 0) ? W'(32'h6) : W'($urandom), rand_hold);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_bram_we", {31'b0, bram_we}, 32'h0);
    chk("rst_bram_addr", bram_addr, 32'h0);
    chk("rst_bram_data", bram_data, 32'h0);
    chk("rst_list_done", {31'b0, list_done}, 32'h0);
    chk("rst_overflow", {31'b0, overflow}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'h0);
  endtask

  task automatic drain_check();
    idle_cycles(3);
    chk("scoreboard_empty", W'(q_addr.size()), 32'h0);
  endtask

  logic [7:0] ops [14] = '{8'h03, 8'h04, 8'h11, 8'h13, 8'h16, 8'h17, 8'h18,
                           8'h1A, 8'h1B, 8'h19, 8'h06, 8'h00, 8'h05, 8'hFF};

  initial begin
    reset = 1'b1; cmd_in = '0; cmd_valid = 1'b0; hold = 1'b0;
    model_reset();
    #1;
    check_reset_outputs();
    #20;
    @(posedge clk); #1;
    reset = 1'b0;

    // Short packet, then a JMP closing the list at address 4.
    send_packet(32'h0000_0003, 1'b0, 1'b0);
    send_word(32'h0000_0006, 1'b0);
    // 17-word packet whose payload includes a JMP pattern.
    send_word(32'h8000_1011, 1'b0);
    for (int i = 1; i < 17; i++) send_word((i == 7) ? 32'h6 : 32'hA000_0000 + W'(i), 1'b0);
    send_word(32'h0000_0006, 1'b0);
    // 17 words under random hold.
    send_packet(32'h0000_0016, 1'b1, 1'b0);
    // Viewport, vertex, then a packet that cannot fit, then a JMP.
    send_packet(32'h0000_0019, 1'b0, 1'b0);
    send_packet(32'h0000_0003, 1'b0, 1'b0);
    send_packet(32'h0000_0011, 1'b1, 1'b0);
    send_word(32'h0000_0006, 1'b0);
    send_packet(32'h0000_0004, 1'b0, 1'b0);
    drain_check();

    // Randomized traffic.
    for (int p = 0; p < 150; p++) begin
      send_packet({$urandom_range(0, 32'hFFFF), 8'h00, ops[$urandom_range(0, 13)]}, 1'b1, 1'b1);
    end
    drain_check();

    // Reset in the middle of a packet.
    send_word(32'h0000_0004, 1'b0);
    send_word(32'h1111_1111, 1'b0);
    send_word(32'h2222_2222, 1'b0);
    idle_cycles(1);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check_reset_outputs();
    model_reset();
    idle_cycles(2);
    reset = 1'b0;
    send_packet(32'h0000_0004, 1'b0, 1'b0);
    send_packet(32'h0000_0019, 1'b1, 1'b1);
    drain_check();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gl_cmd_writer.md
GL_CMD_WRITER -- requirements
Module: gl_cmd_writer

Interface
REQ-001 Parameter: width, 32, data and address word width.
REQ-002 Parameter: depth, 1024, number of instruction BRAM words available to the list.
REQ-003 Parameter: text_start, 0, BRAM address where a command list begins and where writing restarts after a JMP.
REQ-004 Port: clk  input  1  single clock; all outputs registered on its rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-high reset.
REQ-006 Port: cmd_in  input  width  host command stream word (header or payload).
REQ-007 Port: cmd_valid  input  1  cmd_in holds a valid word.
REQ-008 Port: hold  input  1  BRAM port unavailable; no word is accepted while high.
REQ-009 Port: cmd_ready  output  1  word is accepted in a cycle with cmd_valid && cmd_ready.
REQ-010 Port: bram_we  output  1  write strobe to the instruction BRAM.
REQ-011 Port: bram_addr  output  width  write address.
REQ-012 Port: bram_data  output  width  write data.
REQ-013 Port: list_done  output  1  one-cycle pulse when a JMP word is written.
REQ-014 Port: overflow  output  1  sticky flag: a packet was dropped for lack of space.
REQ-015 Port: busy  output  1  high while a packet is partially received (state not IDLE).

Function
REQ-016 The packet length, header included, SHALL be taken from header bits [7:0]: 0x03 and 0x04 give 4; 0x11, 0x13, 0x16, 0x17, 0x18, 0x1A and 0x1B give 17; 0x19 gives 5; 0x06 (JMP) and every other code give 1.
REQ-017 cmd_ready SHALL equal ~hold && ~reset, combinationally.
REQ-018 States: IDLE (await header), PAYLOAD (write remaining words), DROP (discard remaining words).
REQ-019 Header accepted in IDLE, non-JMP, with wr_ptr + len <= depth - 1: write the header and advance. If len > 1, load remaining = len - 1 and go to PAYLOAD. Otherwise stay in IDLE.
REQ-020 Header accepted in IDLE, non-JMP, with wr_ptr + len > depth - 1: write nothing and set overflow. If len > 1, load remaining = len - 1 and go to DROP. Otherwise stay in IDLE. One slot is always reserved for a JMP.
REQ-021 JMP header accepted in IDLE: write it at wr_ptr, pulse list_done in the same cycle bram_we is asserted, set wr_ptr to text_start, and stay in IDLE. A JMP always fits.
REQ-022 PAYLOAD: each accepted word is written at wr_ptr, then wr_ptr increments and remaining decrements. The move to IDLE happens on the word that makes remaining 0.
REQ-023 DROP: each accepted word decrements remaining without a write. The move to IDLE happens when remaining reaches 0.
REQ-024 Write latency: a word accepted at edge N SHALL appear on bram_we/bram_addr/bram_data from edge N to edge N+1, as a one-cycle registered strobe.
REQ-025 bram_we SHALL be 0 in every cycle with no accepted writable word. bram_addr and bram_data hold their last values.
REQ-026 Cycles with cmd_valid low or hold high SHALL leave state, remaining, wr_ptr and outputs unchanged, except that bram_we and list_done drop to 0.
REQ-027 Payload words are never decoded as opcodes, whatever their bit pattern.
REQ-028 overflow SHALL remain set until reset. Later packets that fit are still written normally.
REQ-029 wr_ptr, remaining and internal registers SHALL be width-bit unsigned. Comparisons SHALL use a width+1-bit sum so they cannot wrap.

Reset
REQ-030 While reset is high, and asynchronously on its assertion: state=IDLE, wr_ptr=text_start, remaining=0, bram_we=0, bram_addr=0, bram_data=0, list_done=0, overflow=0, busy=0, cmd_ready=0.
REQ-031 Reset asserted mid-packet SHALL abandon the packet. Words already written stay in BRAM, and the next accepted word after release is treated as a header.

Verification
REQ-032 After reset, send 0x00000003 then 3 payload words with hold=0 -> bram_we high for 4 consecutive cycles at addresses 0..3, busy high for 3 cycles, final wr_ptr=4.
REQ-033 Send 0x80001011 then 16 payload words, one of them equal to 0x00000006 -> 17 writes at addresses 0..16, no list_done pulse, wr_ptr=17.
REQ-034 Send VERTEX packet, then 0x00000006 -> JMP written at address 4, list_done pulses exactly once with bram_we, next header written at address 0.
REQ-035 With depth=8: send VIEWPORT (5 words) then VERTEX (4 words) -> VIEWPORT written at 0..4; VERTEX dropped with overflow=1 and no bram_we for its 4 words; a following JMP is written at address 5.
REQ-036 Toggle hold randomly during a MULTMATRIX packet -> no word accepted while hold=1, and 17 contiguous addresses are written in order.
REQ-037 Assert reset after header plus 2 payload words of a COLOR packet -> all outputs are at their reset values immediately; the next word 0x00000004 is written at address 0 as a header.
